// File: rtl/limn2600_fetch_fill.sv
// ============================================================================
// limn2600_fetch_fill : I-cache line refill engine, critical word first with
//                       wrap-around inside the line.
// Revision 1.0
// ============================================================================
`default_nettype none

module limn2600_fetch_fill #(
  parameter int LINE_WORDS = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_data,
  output logic        cache_we,
  output logic [31:0] cache_addr,
  output logic [31:0] cache_data,
  output logic        done_valid,
  output logic        done_err,
  output logic [31:0] done_addr
);

  localparam int            OFF      = $clog2(LINE_WORDS);
  localparam logic [OFF-1:0] K_LAST  = '1;
  localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [29-OFF:0] base_hi;
  logic [OFF-1:0]  crit;
  logic [OFF-1:0]  k;
  logic [OFF-1:0]  next_off;
  logic [15:0]     tmo;
  logic            tmo_hit;
  logic            last_word;

  assign tmo_hit   = !mem_ack && (tmo == TMO_LAST);
  assign last_word = (k == K_LAST);
  // Offset arithmetic stays OFF bits wide so the word index wraps inside the line.
  assign next_off  = crit + k + OFF'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = READ;
      READ:    if (mem_err || tmo_hit || (mem_ack && last_word)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready  <= 1'b1;
      mem_rd     <= 1'b0;
      mem_addr   <= 32'h0;
      cache_we   <= 1'b0;
      cache_addr <= 32'h0;
      cache_data <= 32'h0;
      done_valid <= 1'b0;
      done_err   <= 1'b0;
      done_addr  <= 32'h0;
      base_hi    <= '0;
      crit       <= '0;
      k          <= '0;
      tmo        <= 16'h0;
    end else begin
      cache_we   <= 1'b0;
      done_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            base_hi   <= req_addr[31:OFF+2];
            crit      <= req_addr[OFF+1:2];
            k         <= '0;
            tmo       <= 16'h0;
            req_ready <= 1'b0;
            mem_rd    <= 1'b1;
            mem_addr  <= req_addr & 32'hFFFF_FFFC;
            done_addr <= req_addr & 32'hFFFF_FFFC;
          end
        end
        READ: begin
          if (mem_err) begin
            // Error wins over a simultaneous ack: the data is dropped.
            mem_rd     <= 1'b0;
            done_valid <= 1'b1;
            done_err   <= 1'b1;
          end else if (mem_ack) begin
            cache_we   <= 1'b1;
            cache_addr <= mem_addr;
            cache_data <= mem_data;
            k          <= k + OFF'(1);
            tmo        <= 16'h0;
            mem_addr   <= {base_hi, next_off, 2'b00};
            if (last_word) begin
              mem_rd     <= 1'b0;
              done_valid <= 1'b1;
              done_err   <= 1'b0;
            end
          end else if (tmo_hit) begin
            mem_rd     <= 1'b0;
            done_valid <= 1'b1;
            done_err   <= 1'b1;
          end else begin
            tmo <= tmo + 16'h1;
          end
        end
        FINISH: req_ready <= 1'b1;
        default: req_ready <= 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_limn2600_fetch_fill.sv
// ============================================================================
// tb_limn2600_fetch_fill : table vectors, random fills against a line-fill
//                          model, reset-mid-burst and timeout sequences.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_limn2600_fetch_fill;

  localparam int LW  = 4;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic        req_ready;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic        mem_err = 1'b0;
  logic [31:0] mem_data = 32'h0;
  logic        cache_we;
  logic [31:0] cache_addr;
  logic [31:0] cache_data;
  logic        done_valid;
  logic        done_err;
  logic [31:0] done_addr;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [63:0] exp_q[$];

  limn2600_fetch_fill #(.LINE_WORDS(LW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_err(mem_err),
    .mem_data(mem_data),
    .cache_we(cache_we), .cache_addr(cache_addr), .cache_data(cache_data),
    .done_valid(done_valid), .done_err(done_err), .done_addr(done_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      addr;
    int               wait_cyc;
    int               err_word;
    bit               err_ack;
    logic [3:0][31:0] exp_addr;
    bit               exp_err;
    int               exp_writes;
    int               exp_cycles;
    logic [31:0]      exp_done_addr;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic set_vec(input int i, input logic [31:0] a, input int w, input int ew,
                         input bit ea, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3, input bit e,
                         input int nw, input int nc, input logic [31:0] da);
    tbl[i].addr = a; tbl[i].wait_cyc = w; tbl[i].err_word = ew; tbl[i].err_ack = ea;
    tbl[i].exp_addr[0] = a0; tbl[i].exp_addr[1] = a1;
    tbl[i].exp_addr[2] = a2; tbl[i].exp_addr[3] = a3;
    tbl[i].exp_err = e; tbl[i].exp_writes = nw; tbl[i].exp_cycles = nc;
    tbl[i].exp_done_addr = da;
  endtask

  // Runs one fill: acts as the bus (waits/acks/errors) and checks every observed cycle.
  task automatic do_fill(input logic [31:0] addr, input logic [3:0][7:0] waits,
                         input int err_word, input bit err_ack,
                         input logic [3:0][31:0] exp_addr, input bit exp_err,
                         input int exp_writes, input int exp_cycles,
                         input logic [31:0] exp_done_addr, input bit hold_req);
    int j, wl, rc, nw, t;
    bit done;
    logic [31:0] d;
    logic [63:0] e;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    chk("ready_before_req", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    if (!hold_req) req_valid = 1'b0;
    chk("crit_word_latency", {31'h0, mem_rd}, 32'h1);
    j = 0; wl = int'(waits[0]); rc = 0; nw = 0; done = 1'b0; t = 0;
    while (!done && t < 400) begin
      if (cache_we) begin
        if (exp_q.size() == 0) chk("unexpected_cache_we", cache_addr, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("cache_addr", cache_addr, e[63:32]);
          chk("cache_data", cache_data, e[31:0]);
        end
        nw++;
      end
      if (done_valid) begin
        chk("done_err", {31'h0, done_err}, {31'h0, exp_err});
        chk("done_addr", done_addr, exp_done_addr);
        chk("read_cycles", rc, exp_cycles);
        chk("write_count", nw, exp_writes);
        chk("rd_low_in_finish", {31'h0, mem_rd}, 32'h0);
        chk("ready_low_in_finish", {31'h0, req_ready}, 32'h0);
        done = 1'b1;
        mem_ack = 1'($urandom_range(0, 1));
        mem_err = 1'($urandom_range(0, 1));
      end else if (mem_rd) begin
        rc++;
        if (j < LW) chk("mem_addr", mem_addr, exp_addr[j]);
        mem_ack = 1'b0;
        mem_err = 1'b0;
        if (wl > 0) wl--;
        else if (j == err_word) begin
          mem_err  = 1'b1;
          mem_ack  = err_ack;
          mem_data = $urandom;
        end else begin
          d = $urandom;
          mem_ack  = 1'b1;
          mem_data = d;
          exp_q.push_back({exp_addr[j], d});
          j++;
          if (j < LW) wl = int'(waits[j]);
        end
      end else begin
        chk("bubble_in_read", {31'h0, mem_rd}, 32'h1);
      end
      if (!done) begin @(negedge clk); t++; end
    end
    if (!done) chk("done_timeout", 32'h0, 32'h1);
    @(negedge clk);
    mem_ack = 1'b0;
    mem_err = 1'b0;
    chk("post_done_quiet", {30'h0, cache_we, done_valid}, 32'h0);
    chk("post_done_ready", {31'h0, req_ready}, 32'h1);
    chk("queue_drained", exp_q.size(), 32'h0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][7:0]  w;
    logic [3:0][31:0] ea;
    logic [31:0]      a, base;
    int               ew, cyc, crit;
    bit               eack;

    set_vec(0, 32'h0000_1008, 0, -1, 0, 32'h1008, 32'h100C, 32'h1000, 32'h1004, 0, 4, 4,  32'h1008);
    set_vec(1, 32'hFFFF_FFFC, 0, -1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8,
            0, 4, 4, 32'hFFFF_FFFC);
    set_vec(2, 32'h0000_2000, 3, -1, 0, 32'h2000, 32'h2004, 32'h2008, 32'h200C, 0, 4, 16, 32'h2000);
    set_vec(3, 32'h0000_3004, 0,  2, 1, 32'h3004, 32'h3008, 32'h300C, 32'h3000, 1, 2, 3,  32'h3004);
    set_vec(4, 32'h0000_4000, 1,  0, 0, 32'h4000, 32'h4004, 32'h4008, 32'h400C, 1, 0, 2,  32'h4000);
    set_vec(5, 32'h0000_5003, 2, -1, 0, 32'h5000, 32'h5004, 32'h5008, 32'h500C, 0, 4, 12, 32'h5000);

    // Reset values
    #12;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_cache", {30'h0, cache_we, done_valid}, 32'h0);
    chk("rst_cache_addr", cache_addr | cache_data, 32'h0);
    chk("rst_done", done_addr | {31'h0, done_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      w = {4{8'(tbl[i].wait_cyc)}};
      do_fill(tbl[i].addr, w, tbl[i].err_word, tbl[i].err_ack, tbl[i].exp_addr,
              tbl[i].exp_err, tbl[i].exp_writes, tbl[i].exp_cycles,
              tbl[i].exp_done_addr, 1'b0);
    end

    // Timeout with req_valid held, then the held request is taken once ready returns
    w = {4{8'd200}};
    ea[0] = 32'h7008; ea[1] = 32'h700C; ea[2] = 32'h7000; ea[3] = 32'h7004;
    do_fill(32'h7008, w, -1, 0, ea, 1, 0, TMO, 32'h7008, 1'b1);
    w = '0;
    do_fill(32'h7008, w, -1, 0, ea, 0, 4, 4, 32'h7008, 1'b0);

    // Random fills against the line-fill model
    for (int n = 0; n < 30; n++) begin
      a    = $urandom;
      base = a & 32'hFFFF_FFF0;
      crit = int'(a[3:2]);
      for (int j = 0; j < LW; j++) begin
        w[j]  = 8'($urandom_range(0, 3));
        ea[j] = base + 32'(((crit + j) % LW) * 4);
      end
      ew   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      eack = 1'($urandom_range(0, 1));
      cyc  = 0;
      for (int j = 0; j < LW; j++)
        if (ew < 0 || j <= ew) cyc += int'(w[j]) + 1;
      do_fill(a, w, ew, eack, ea, (ew >= 0), (ew >= 0) ? ew : LW, cyc,
              a & 32'hFFFF_FFFC, 1'b0);
    end

    // Asynchronous reset after two of four acks
    req_valid = 1'b1;
    req_addr  = 32'h6000;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ack   = 1'b1;
    mem_data  = 32'h1111_1111;
    @(negedge clk);
    mem_data  = 32'h2222_2222;
    @(negedge clk);
    chk("pre_rst_cache_we", {31'h0, cache_we}, 32'h1);
    chk("pre_rst_cache_data", cache_data, 32'h2222_2222);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mem_rd", {31'h0, mem_rd}, 32'h0);
    chk("async_rst_we_done", {30'h0, cache_we, done_valid}, 32'h0);
    chk("async_rst_ready", {31'h0, req_ready}, 32'h1);
    chk("async_rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", {29'h0, cache_we, done_valid, mem_rd}, 32'h0);
    end
    mem_ack = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/limn2600_fetch_fill.md
# limn2600_fetch_fill

Refill engine on the write side of the Limn2600 instruction cache. On a miss request from the fetch stage it reads one cache line from the memory bus, critical word first with wrap-around inside the line. Each returned word goes to the cache write port (`cache_we`/`cache_addr`/`cache_data`), and the engine signals completion or bus error back to fetch. It sits between the fetch stage, the memory bus and the cache array's write interface.

## Interface
Parameters:
- `LINE_WORDS`, 4: 32-bit words per line; power of two, 2..16.
- `TIMEOUT`, 255: maximum cycles to wait for `mem_ack` on one word; 1..65535.

Ports:
- `clk` in 1: sole clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: fetch requests a line fill.
- `req_addr` in 32: miss address; bits [1:0] are ignored.
- `req_ready` out 1: engine idle, request accepted this cycle if `req_valid`.
- `mem_rd` out 1: bus read request, held until acknowledged.
- `mem_addr` out 32: word-aligned bus read address.
- `mem_ack` in 1: read data valid this cycle.
- `mem_err` in 1: bus error for the current read.
- `mem_data` in 32: read data.
- `cache_we` out 1: one-cycle cache write strobe.
- `cache_addr` out 32: cache write address, word-aligned.
- `cache_data` out 32: cache write data.
- `done_valid` out 1: one-cycle completion pulse.
- `done_err` out 1: qualifies `done_valid`; 1 = fill aborted.
- `done_addr` out 32: original `req_addr` with [1:0] cleared, valid with `done_valid`.

## Operation
- States: IDLE, READ, FINISH.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch `base = req_addr & ~(LINE_WORDS*4-1)` and `crit = req_addr[log2(LINE_WORDS)+1:2]`.
  - Clear word counter `k` and timeout counter; go to READ.
- READ:
  - `mem_rd`=1; `mem_addr = base + (((crit+k) mod LINE_WORDS) << 2)`. The offset wraps inside the line and never carries into base.
  - `mem_ack` && !`mem_err`:
    - Next cycle: `cache_we`=1, `cache_addr` = the acknowledged `mem_addr`, `cache_data` = registered `mem_data`.
    - Increment `k` and clear the timeout counter.
    - If `k` was `LINE_WORDS-1`, go to FINISH.
  - `mem_err` (with or without `mem_ack`): discard the data, no cache write, go to FINISH with error. Error wins over ack.
  - Neither ack nor error: increment the timeout counter. When it reaches `TIMEOUT` without an ack, abort with error to FINISH.
- FINISH (one cycle):
  - `done_valid`=1; `done_err` = error flag; `done_addr` = the request address.
  - `mem_rd`=0; go to IDLE.
- `mem_ack`/`mem_err` outside READ are ignored.
- `req_valid` outside IDLE is ignored; it is not queued.
- Address arithmetic is 32-bit modulo. A line at 0xFFFFFFF0 reads only within that line.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready`=1.
  - `mem_rd`=0, `mem_addr`=0.
  - `cache_we`=0, `cache_addr`=0, `cache_data`=0.
  - `done_valid`=0, `done_err`=0, `done_addr`=0.
- All outputs are registered.
- Request accepted at edge E: `mem_rd`=1 with the critical-word address from cycle E+1.
- Ack sampled at edge A:
  - `cache_we` pulses in cycle A+1.
  - `mem_addr` shows the next word in A+1; `mem_rd` stays high, with no bubble.
- Zero-wait bus, ack every cycle: a 4-word fill takes 4 READ cycles.
  - The last `cache_we` and `done_valid` coincide in the cycle after the last ack.
  - `req_ready`=1 the following cycle.
  - Best-case request-to-`done_valid` latency is LINE_WORDS+1 cycles.
- The aborting error/timeout cycle produces no `cache_we`. Writes already issued for earlier words stand.
- Reset mid-burst:
  - All outputs drop immediately (asynchronous).
  - No further `cache_we`; no `done_valid` is generated for the aborted fill.

## Test plan
- Reset asserted mid-READ after 2 of 4 acks -> `mem_rd`, `cache_we` and `done_valid` go 0 without waiting for a clock edge; `req_ready`=1; no further writes after release.
- `req_addr`=0x00001008, LINE_WORDS=4, ack every cycle, data 0xA0..0xA3 -> `mem_addr` 0x1008, 0x100C, 0x1000, 0x1004. Four `cache_we` pulses with the matching addresses and data. `done_valid`=1, `done_err`=0, `done_addr`=0x1008, all 5 cycles after acceptance.
- `req_addr`=0xFFFFFFFC -> reads 0xFFFFFFFC, 0xFFFFFFF0, 0xFFFFFFF4, 0xFFFFFFF8; never 0x00000000.
- Ack with 3 wait cycles per word -> `mem_addr` is stable while waiting and `cache_we` appears exactly once per ack.
- `mem_err` and `mem_ack` together on word 2 -> two `cache_we` pulses only; `done_valid`=1 with `done_err`=1 the next cycle.
- TIMEOUT=8, no ack -> `done_err`=1 after 8 READ cycles with no `cache_we`. `req_valid` held throughout is not accepted until `req_ready` returns.
